// File: rtl/spell_ram_arbiter_if.sv
// Requester and shared-RAM Wishbone signal bundle for spell_ram_arbiter.
// master: the arbiter's view (serves requesters a/b, masters the RAM bus).
// slave : the opposite view (requesters plus RAM model).
interface spell_ram_arbiter_if;
  // requester a (core)
  logic        a_req;
  logic        a_we;
  logic [3:0]  a_sel;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic        a_ack;
  logic        a_err;
  logic [31:0] a_rdata;
  // requester b (host)
  logic        b_req;
  logic        b_we;
  logic [3:0]  b_sel;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata;
  logic        b_ack;
  logic        b_err;
  logic [31:0] b_rdata;
  // shared RAM Wishbone bus
  logic        rambus_wb_cyc_o;
  logic        rambus_wb_stb_o;
  logic        rambus_wb_we_o;
  logic [3:0]  rambus_wb_sel_o;
  logic [7:0]  rambus_wb_addr_o;
  logic [31:0] rambus_wb_dat_o;
  logic        rambus_wb_ack_i;
  logic [31:0] rambus_wb_dat_i;

  modport master (
    input  a_req, a_we, a_sel, a_addr, a_wdata,
    output a_ack, a_err, a_rdata,
    input  b_req, b_we, b_sel, b_addr, b_wdata,
    output b_ack, b_err, b_rdata,
    output rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o,
    output rambus_wb_sel_o, rambus_wb_addr_o, rambus_wb_dat_o,
    input  rambus_wb_ack_i, rambus_wb_dat_i
  );

  modport slave (
    output a_req, a_we, a_sel, a_addr, a_wdata,
    input  a_ack, a_err, a_rdata,
    output b_req, b_we, b_sel, b_addr, b_wdata,
    input  b_ack, b_err, b_rdata,
    input  rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o,
    input  rambus_wb_sel_o, rambus_wb_addr_o, rambus_wb_dat_o,
    output rambus_wb_ack_i, rambus_wb_dat_i
  );
endinterface

// File: rtl/spell_ram_arbiter.sv
// Two-requester (a = core, b = host) round-robin arbiter onto a shared-RAM
// Wishbone bus. One transfer at a time: IDLE -> BUS -> RESP -> IDLE.
// Optional transfer timeout is enabled by defining SPELL_ARB_TIMEOUT_EN;
// without it BUS waits indefinitely, err/timeout_flag are tied low.
module spell_ram_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic                clock,
  input  logic                reset_n,
  spell_ram_arbiter_if.master bus,
  output logic                rambus_wb_clk_o,
  output logic                rambus_wb_rst_o,
  output logic                busy,
  output logic                timeout_flag,
  input  logic                timeout_clr
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t state_reg, state_next;

  // requester views indexed by requester id (0 = a, 1 = b)
  logic        req_vec   [2];
  logic        we_vec    [2];
  logic [3:0]  sel_vec   [2];
  logic [7:0]  addr_vec  [2];
  logic [31:0] wdata_vec [2];

  logic [1:0]  ack_reg;
  logic [1:0]  err_reg;
  logic [31:0] rdata_reg [2];

  // bus-side registers
  logic        cyc_reg, cyc_next;
  logic        we_reg, we_next;
  logic [3:0]  sel_reg, sel_next;
  logic [7:0]  addr_reg, addr_next;
  logic [31:0] dat_reg, dat_next;

  logic        grant_reg, grant_next;
  logic        last_grant_reg, last_grant_next;
  logic        pick;
  logic        done_pulse;
  logic        abort_pulse;
  logic        timeout_hit;

  assign req_vec[0]   = bus.a_req;
  assign we_vec[0]    = bus.a_we;
  assign sel_vec[0]   = bus.a_sel;
  assign addr_vec[0]  = bus.a_addr;
  assign wdata_vec[0] = bus.a_wdata;
  assign req_vec[1]   = bus.b_req;
  assign we_vec[1]    = bus.b_we;
  assign sel_vec[1]   = bus.b_sel;
  assign addr_vec[1]  = bus.b_addr;
  assign wdata_vec[1] = bus.b_wdata;

  assign bus.a_ack   = ack_reg[0];
  assign bus.a_err   = err_reg[0];
  assign bus.a_rdata = rdata_reg[0];
  assign bus.b_ack   = ack_reg[1];
  assign bus.b_err   = err_reg[1];
  assign bus.b_rdata = rdata_reg[1];

  assign bus.rambus_wb_cyc_o  = cyc_reg;
  assign bus.rambus_wb_stb_o  = cyc_reg;
  assign bus.rambus_wb_we_o   = we_reg;
  assign bus.rambus_wb_sel_o  = sel_reg;
  assign bus.rambus_wb_addr_o = addr_reg;
  assign bus.rambus_wb_dat_o  = dat_reg;

  assign rambus_wb_clk_o = clock;
  assign rambus_wb_rst_o = ~reset_n;
  assign busy            = (state_reg != IDLE);

  // Next-state and bus-register decode; requests are only looked at in IDLE.
  always_comb begin
    state_next      = state_reg;
    cyc_next        = cyc_reg;
    we_next         = we_reg;
    sel_next        = sel_reg;
    addr_next       = addr_reg;
    dat_next        = dat_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    pick            = 1'b0;
    done_pulse      = 1'b0;
    abort_pulse     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_vec[0] || req_vec[1]) begin
          // on a tie the requester that did not win last time goes first
          if (req_vec[0] && req_vec[1]) pick = ~last_grant_reg;
          else                          pick = req_vec[1];
          state_next      = BUS;
          grant_next      = pick;
          last_grant_next = pick;
          cyc_next        = 1'b1;
          we_next         = we_vec[pick];
          sel_next        = sel_vec[pick];
          addr_next       = addr_vec[pick];
          dat_next        = wdata_vec[pick];
        end
      end
      BUS: begin
        // a RAM ack wins over a timeout landing in the same cycle
        if (bus.rambus_wb_ack_i) begin
          state_next = RESP;
          cyc_next   = 1'b0;
          we_next    = 1'b0;
          done_pulse = 1'b1;
        end else if (timeout_hit) begin
          state_next  = RESP;
          cyc_next    = 1'b0;
          we_next     = 1'b0;
          abort_pulse = 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and bus-side registers; reset abandons any transfer in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      cyc_reg        <= 1'b0;
      we_reg         <= 1'b0;
      sel_reg        <= 4'h0;
      addr_reg       <= 8'h00;
      dat_reg        <= 32'h0;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      cyc_reg        <= cyc_next;
      we_reg         <= we_next;
      sel_reg        <= sel_next;
      addr_reg       <= addr_next;
      dat_reg        <= dat_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    localparam logic REQ_ID = (gi == 1);
    logic hit;
    assign hit = (grant_reg == REQ_ID) && (done_pulse || abort_pulse);

    // Per-requester response: ack/err/rdata are one-cycle, visible in RESP.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        ack_reg[gi]   <= 1'b0;
        err_reg[gi]   <= 1'b0;
        rdata_reg[gi] <= 32'h0;
      end else begin
        ack_reg[gi]   <= hit;
        err_reg[gi]   <= hit && abort_pulse;
        rdata_reg[gi] <= (hit && done_pulse) ? bus.rambus_wb_dat_i : 32'h0;
      end
    end
  end

`ifdef SPELL_ARB_TIMEOUT_EN
  logic [15:0] count_reg;
  logic        flag_reg;

  // a zero limit never matches, which disables the abort
  assign timeout_hit  = (TIMEOUT_CYCLES != 16'd0) &&
                        (count_reg == TIMEOUT_CYCLES - 16'd1);
  assign timeout_flag = flag_reg;

  // Counts BUS cycles without ack; cleared while idle so each grant starts at 0.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_reg <= 16'd0;
    end else if (state_reg == IDLE) begin
      count_reg <= 16'd0;
    end else if (state_reg == BUS && !bus.rambus_wb_ack_i) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  // Sticky abort flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      flag_reg <= 1'b0;
    end else if (abort_pulse) begin
      flag_reg <= 1'b1;
    end else if (timeout_clr) begin
      flag_reg <= 1'b0;
    end
  end
`else
  localparam logic [15:0] UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
  logic unused_timeout_clr;

  assign unused_timeout_clr = timeout_clr;
  assign timeout_hit        = 1'b0;
  assign timeout_flag       = 1'b0;
`endif

endmodule

// File: tb/tb_spell_ram_arbiter.sv
// Directed self-checking bench for spell_ram_arbiter.
module tb_spell_ram_arbiter;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic timeout_clr = 1'b0;
  logic rambus_wb_clk_o;
  logic rambus_wb_rst_o;
  logic busy;
  logic timeout_flag;

  int errors = 0;
  int checks = 0;

  spell_ram_arbiter_if bus_if ();

  spell_ram_arbiter #(.TIMEOUT_CYCLES(16'd8)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .bus             (bus_if),
    .rambus_wb_clk_o (rambus_wb_clk_o),
    .rambus_wb_rst_o (rambus_wb_rst_o),
    .busy            (busy),
    .timeout_flag    (timeout_flag),
    .timeout_clr     (timeout_clr)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus_if.a_req = 0; bus_if.a_we = 0; bus_if.a_sel = 4'h0; bus_if.a_addr = 8'h00; bus_if.a_wdata = 32'h0;
    bus_if.b_req = 0; bus_if.b_we = 0; bus_if.b_sel = 4'h0; bus_if.b_addr = 8'h00; bus_if.b_wdata = 32'h0;
    bus_if.rambus_wb_ack_i = 0; bus_if.rambus_wb_dat_i = 32'h0;

    // reset state
    reset_n = 1'b0;
    tick();
    tick();
    check_eq("rst_cyc", 32'(bus_if.rambus_wb_cyc_o), 32'd0);
    check_eq("rst_stb", 32'(bus_if.rambus_wb_stb_o), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_a_ack", 32'(bus_if.a_ack), 32'd0);
    check_eq("rst_flag", 32'(timeout_flag), 32'd0);
    check_eq("rst_rst_o", 32'(rambus_wb_rst_o), 32'd1);
    reset_n = 1'b1;
    tick();
    check_eq("run_rst_o", 32'(rambus_wb_rst_o), 32'd0);

    // single read from a, RAM acks in the first BUS cycle
    bus_if.a_req = 1; bus_if.a_addr = 8'h10; bus_if.a_we = 0; bus_if.a_sel = 4'hF;
    tick();
    check_eq("rd_cyc", 32'(bus_if.rambus_wb_cyc_o), 32'd1);
    check_eq("rd_stb", 32'(bus_if.rambus_wb_stb_o), 32'd1);
    check_eq("rd_addr", 32'(bus_if.rambus_wb_addr_o), 32'h10);
    check_eq("rd_we", 32'(bus_if.rambus_wb_we_o), 32'd0);
    check_eq("rd_busy", 32'(busy), 32'd1);
    bus_if.rambus_wb_ack_i = 1; bus_if.rambus_wb_dat_i = 32'hDEADBEEF;
    tick();
    check_eq("rd_a_ack", 32'(bus_if.a_ack), 32'd1);
    check_eq("rd_a_rdata", bus_if.a_rdata, 32'hDEADBEEF);
    check_eq("rd_b_ack", 32'(bus_if.b_ack), 32'd0);
    check_eq("rd_cyc_drop", 32'(bus_if.rambus_wb_cyc_o), 32'd0);
    $display("xfer read a addr=10 rdata=%h", bus_if.a_rdata);
    bus_if.a_req = 0; bus_if.rambus_wb_ack_i = 0;
    tick();
    check_eq("rd_ack_once", 32'(bus_if.a_ack), 32'd0);
    check_eq("rd_idle", 32'(busy), 32'd0);
    tick();
    check_eq("rd_no_dup", 32'(bus_if.rambus_wb_cyc_o), 32'd0);

    // stray RAM ack while idle is ignored
    bus_if.rambus_wb_ack_i = 1;
    tick();
    check_eq("stray_busy", 32'(busy), 32'd0);
    check_eq("stray_a_ack", 32'(bus_if.a_ack), 32'd0);
    check_eq("stray_b_ack", 32'(bus_if.b_ack), 32'd0);
    bus_if.rambus_wb_ack_i = 0;

    // tie after reset and fairness: both held, grant order a,b,a,b
    reset_dut();
    bus_if.a_req = 1; bus_if.a_addr = 8'h20;
    bus_if.b_req = 1; bus_if.b_addr = 8'h30; bus_if.b_we = 0;
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = logic'(i % 2);
      tick();
      check_eq($sformatf("fair%0d_addr", i), 32'(bus_if.rambus_wb_addr_o), g ? 32'h30 : 32'h20);
      bus_if.rambus_wb_ack_i = 1; bus_if.rambus_wb_dat_i = 32'hA0 + i;
      tick();
      check_eq($sformatf("fair%0d_a_ack", i), 32'(bus_if.a_ack), g ? 32'd0 : 32'd1);
      check_eq($sformatf("fair%0d_b_ack", i), 32'(bus_if.b_ack), g ? 32'd1 : 32'd0);
      check_eq($sformatf("fair%0d_a_rdata", i), bus_if.a_rdata, g ? 32'h0 : 32'hA0 + i);
      check_eq($sformatf("fair%0d_b_rdata", i), bus_if.b_rdata, g ? 32'hA0 + i : 32'h0);
      $display("xfer fair %0d granted %s", i, g ? "b" : "a");
      bus_if.rambus_wb_ack_i = 0;
      tick();
      check_eq($sformatf("fair%0d_idle", i), 32'(busy), 32'd0);
    end
    bus_if.a_req = 0; bus_if.b_req = 0;
    tick();

    // write from b, RAM acks in the fifth BUS cycle
    bus_if.b_req = 1; bus_if.b_we = 1; bus_if.b_sel = 4'hF; bus_if.b_addr = 8'h44;
    bus_if.b_wdata = 32'h12345678; bus_if.rambus_wb_dat_i = 32'h55AA55AA;
    tick();
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("wr_dat_c%0d", k), bus_if.rambus_wb_dat_o, 32'h12345678);
      check_eq($sformatf("wr_we_c%0d", k), 32'(bus_if.rambus_wb_we_o), 32'd1);
      check_eq($sformatf("wr_b_ack_c%0d", k), 32'(bus_if.b_ack), 32'd0);
      if (k == 4) bus_if.rambus_wb_ack_i = 1;
      tick();
    end
    check_eq("wr_b_ack", 32'(bus_if.b_ack), 32'd1);
    check_eq("wr_b_rdata", bus_if.b_rdata, 32'h55AA55AA);
    check_eq("wr_b_err", 32'(bus_if.b_err), 32'd0);
    check_eq("wr_a_ack", 32'(bus_if.a_ack), 32'd0);
    check_eq("wr_sel", 32'(bus_if.rambus_wb_sel_o), 32'hF);
    $display("xfer write b addr=44 wdata=12345678");
    bus_if.b_req = 0; bus_if.b_we = 0; bus_if.rambus_wb_ack_i = 0;
    tick();
    check_eq("wr_ack_once", 32'(bus_if.b_ack), 32'd0);

    // reset mid-BUS after a was last granted; next tie must still go to a
    bus_if.a_req = 1; bus_if.a_addr = 8'h20;
    tick();
    check_eq("mid_cyc_pre", 32'(bus_if.rambus_wb_cyc_o), 32'd1);
    bus_if.a_req = 0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_eq("mid_cyc", 32'(bus_if.rambus_wb_cyc_o), 32'd0);
    check_eq("mid_stb", 32'(bus_if.rambus_wb_stb_o), 32'd0);
    check_eq("mid_a_ack", 32'(bus_if.a_ack), 32'd0);
    check_eq("mid_busy", 32'(busy), 32'd0);
    bus_if.a_req = 1; bus_if.b_req = 1; bus_if.b_addr = 8'h30;
    tick();
    check_eq("mid_tie_addr", 32'(bus_if.rambus_wb_addr_o), 32'h20);
    bus_if.rambus_wb_ack_i = 1; bus_if.rambus_wb_dat_i = 32'h0BADF00D;
    tick();
    check_eq("mid_tie_a_ack", 32'(bus_if.a_ack), 32'd1);
    $display("xfer after mid-bus reset granted a");
    bus_if.a_req = 0; bus_if.b_req = 0; bus_if.rambus_wb_ack_i = 0;
    tick();

    // RAM that never acks
    bus_if.a_req = 1; bus_if.a_addr = 8'h55; bus_if.rambus_wb_dat_i = 32'hBAD0BAD0;
    tick();
`ifdef SPELL_ARB_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("to_cyc_c%0d", k), 32'(bus_if.rambus_wb_cyc_o), 32'd1);
      tick();
    end
    check_eq("to_cyc_drop", 32'(bus_if.rambus_wb_cyc_o), 32'd0);
    check_eq("to_a_ack", 32'(bus_if.a_ack), 32'd1);
    check_eq("to_a_err", 32'(bus_if.a_err), 32'd1);
    check_eq("to_a_rdata", bus_if.a_rdata, 32'h0);
    check_eq("to_flag", 32'(timeout_flag), 32'd1);
    $display("xfer read a aborted by timeout");
    bus_if.a_req = 0;
    tick();
    check_eq("to_ack_once", 32'(bus_if.a_ack), 32'd0);
    check_eq("to_flag_hold", 32'(timeout_flag), 32'd1);
    timeout_clr = 1;
    tick();
    timeout_clr = 0;
    check_eq("to_flag_clr", 32'(timeout_flag), 32'd0);
`else
    for (int k = 0; k < 20; k++) tick();
    check_eq("nto_cyc", 32'(bus_if.rambus_wb_cyc_o), 32'd1);
    check_eq("nto_a_ack", 32'(bus_if.a_ack), 32'd0);
    check_eq("nto_flag", 32'(timeout_flag), 32'd0);
    bus_if.rambus_wb_ack_i = 1;
    tick();
    check_eq("nto_a_ack_late", 32'(bus_if.a_ack), 32'd1);
    check_eq("nto_a_err", 32'(bus_if.a_err), 32'd0);
    check_eq("nto_a_rdata", bus_if.a_rdata, 32'hBAD0BAD0);
    $display("xfer read a completed after long wait");
    bus_if.a_req = 0; bus_if.rambus_wb_ack_i = 0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
